prio_encoder_rr: RTL and testbench

Parametrised N-to-log2(N) priority encoder with a registered, handshaked output and a selectable round-robin mode. It is the successor to the team's fixed 8x3 combinational encoder. It generalises input width, flags zero and multiple-hot inputs, and can rotate priority so repeated multi-hot requests are served fairly. It sits between request sources (interrupt lines, channel requests) and a consumer that accepts one encoded index per transfer.

---
 rtl/prio_encoder_rr_pkg.sv | 28 ++
 rtl/prio_encoder_rr_pick.sv | 50 +++++
 rtl/prio_encoder_rr.sv | 113 +++++++++++
 tb/tb_prio_encoder_rr.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prio_encoder_rr_pkg
//  Purpose  : Shared constants and helpers for the round-robin priority
//             encoder (mode encoding, code-width calculation).
//  Revision : 1.0  initial release
// ============================================================================
package prio_encoder_rr_pkg;

   // Priority-mode encoding for the ROUND_ROBIN parameter
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Ceiling log2, used to validate the code width against the vector width
   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_encoder_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational search for the first set bit at or above a start
//             index, wrapping from N-1 back to 0. Also flags multiple-hot.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] data,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found,
   output logic         multi
);

   // N expressed at code width + 1 so the wrap compare cannot overflow
   localparam logic [W:0] C_N = (W+1)'(N);

   logic [N-1:0] w_rot;
   logic [W-1:0] w_off;
   logic [W:0]   w_sum;

   // Rotating right by start through a doubled vector; start is always < N,
   // so the low N bits are exactly data rotated by start.
   assign w_rot = N'({data, data} >> start);

   // Lowest set bit of the rotated vector: scan downward so the last hit wins
   always_comb begin
      w_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = W'(i);
         end
      end
   end

   // Undo the rotation; the sum wraps at N, not at 2^W
   assign w_sum = {1'b0, w_off} + {1'b0, start};
   assign found = |data;
   assign idx   = !found         ? '0 :
                  (w_sum >= C_N) ? W'(w_sum - C_N) : w_sum[W-1:0];

   // Clearing the lowest set bit leaves something only if two or more were set
   assign multi = |(data & (data - 1'b1));

endmodule
`default_nettype wire

// File: rtl/prio_encoder_rr.sv
`default_nettype none
// ============================================================================
//  Module   : prio_encoder_rr
//  Purpose  : N-to-log2(N) priority encoder with a registered valid/ready
//             output stage and optional rotating (round-robin) priority.
//  Revision : 1.0  initial release
// ============================================================================
module prio_encoder_rr
   import prio_encoder_rr_pkg::*;
#(
   parameter int N           = 8,
   parameter int W           = 3,
   parameter int ROUND_ROBIN = MODE_FIXED
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] code,
   output logic         none,
   output logic         multi,
   output logic         out_valid,
   input  logic         out_ready
);

   // Reject illegal parameterisations at elaboration time
   generate
      if (N < 2 || N > 256) begin : g_bad_n
         $error("prio_encoder_rr: N=%0d is outside 2..256", N);
      end
      if (W != clog2(N)) begin : g_bad_w
         $error("prio_encoder_rr: W=%0d must equal clog2(N)=%0d", W, clog2(N));
      end
      if (ROUND_ROBIN != MODE_FIXED && ROUND_ROBIN != MODE_RR) begin : g_bad_mode
         $error("prio_encoder_rr: ROUND_ROBIN=%0d is not a legal mode", ROUND_ROBIN);
      end
   endgenerate

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] code_q,      code_d;
   logic         none_q,      none_d;
   logic         multi_q,     multi_d;
   logic [W-1:0] ptr_q,       ptr_d;

   logic         w_accept;
   logic         w_xfer;
   logic [W-1:0] w_pick_idx;
   logic         w_pick_found;
   logic         w_pick_multi;

   // Single pipe stage: room exists when empty or when the result leaves now
   assign in_ready = !out_valid_q || out_ready;
   assign w_accept = in_valid && in_ready;
   assign w_xfer   = out_valid_q && out_ready;

   // ptr never leaves 0 in fixed mode, so it doubles as the fixed start index
   rr_pick #(
      .N (N),
      .W (W)
   ) u_pick (
      .data  (data),
      .start (ptr_q),
      .idx   (w_pick_idx),
      .found (w_pick_found),
      .multi (w_pick_multi)
   );

   // Next-state: load a new result on accept, drop valid on a bare transfer
   always_comb begin
      out_valid_d = out_valid_q;
      code_d      = code_q;
      none_d      = none_q;
      multi_d     = multi_q;
      ptr_d       = ptr_q;
      if (w_accept) begin
         out_valid_d = 1'b1;
         code_d      = w_pick_idx;
         none_d      = !w_pick_found;
         multi_d     = w_pick_multi;
         // Next search starts just past the winner; a zero vector leaves it alone
         if (ROUND_ROBIN == MODE_RR && w_pick_found) begin
            ptr_d = (w_pick_idx == W'(N - 1)) ? '0 : w_pick_idx + 1'b1;
         end
      end else if (w_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset wins over any same-cycle accept or transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         code_q      <= '0;
         none_q      <= 1'b0;
         multi_q     <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         code_q      <= code_d;
         none_q      <= none_d;
         multi_q     <= multi_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign code      = code_q;
   assign none      = none_q;
   assign multi     = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_encoder_rr
//  Purpose  : Self-checking bench for prio_encoder_rr: three instances
//             (N=8 fixed, N=8 round-robin, N=5 round-robin) share one
//             stimulus path; a reference search model feeds a scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prio_encoder_rr;

   typedef struct packed {
      logic [2:0] code;
      logic       none;
      logic       multi;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] data;
   logic       out_ready;
   logic [1:0] sel;

   logic       iv_f, ir_f, none_f, multi_f, ov_f;
   logic       iv_r, ir_r, none_r, multi_r, ov_r;
   logic       iv_5, ir_5, none_5, multi_5, ov_5;
   logic [2:0] code_f, code_r, code_5;

   logic       o_in_ready, o_none, o_multi, o_valid;
   logic [2:0] o_code;

   int   vectors     = 0;
   int   miscompares = 0;
   res_t exp_q[$];
   int   model_ptr[3];

   always #5 clk = ~clk;

   assign iv_f = in_valid && (sel == 2'd0);
   assign iv_r = in_valid && (sel == 2'd1);
   assign iv_5 = in_valid && (sel == 2'd2);

   prio_encoder_rr #(.N(8), .W(3), .ROUND_ROBIN(0)) u_fix (
      .clk(clk), .rst(rst), .data(data), .in_valid(iv_f), .in_ready(ir_f),
      .code(code_f), .none(none_f), .multi(multi_f), .out_valid(ov_f), .out_ready(out_ready));

   prio_encoder_rr #(.N(8), .W(3), .ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst(rst), .data(data), .in_valid(iv_r), .in_ready(ir_r),
      .code(code_r), .none(none_r), .multi(multi_r), .out_valid(ov_r), .out_ready(out_ready));

   prio_encoder_rr #(.N(5), .W(3), .ROUND_ROBIN(1)) u_n5 (
      .clk(clk), .rst(rst), .data(data[4:0]), .in_valid(iv_5), .in_ready(ir_5),
      .code(code_5), .none(none_5), .multi(multi_5), .out_valid(ov_5), .out_ready(out_ready));

   // Outputs of the instance currently under test
   assign o_in_ready = (sel == 2'd0) ? ir_f    : (sel == 2'd1) ? ir_r    : ir_5;
   assign o_code     = (sel == 2'd0) ? code_f  : (sel == 2'd1) ? code_r  : code_5;
   assign o_none     = (sel == 2'd0) ? none_f  : (sel == 2'd1) ? none_r  : none_5;
   assign o_multi    = (sel == 2'd0) ? multi_f : (sel == 2'd1) ? multi_r : multi_5;
   assign o_valid    = (sel == 2'd0) ? ov_f    : (sel == 2'd1) ? ov_r    : ov_5;

   // Reference: walk upward from the start index, first set bit wins
   task automatic model_push(input logic [7:0] d);
      int   n;
      bit   rr;
      int   s;
      int   cnt;
      int   ix;
      res_t r;
      n   = (sel == 2'd2) ? 5 : 8;
      rr  = (sel != 2'd0);
      s   = rr ? model_ptr[sel] : 0;
      r   = '{code: 3'd0, none: 1'b1, multi: 1'b0};
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         if (d[k[2:0]]) cnt++;
         ix = (s + k) % n;
         if (r.none && d[ix[2:0]]) begin
            r.code = ix[2:0];
            r.none = 1'b0;
         end
      end
      r.multi = (cnt >= 2);
      if (rr && !r.none) model_ptr[sel] = (int'(r.code) + 1) % n;
      exp_q.push_back(r);
   endtask

   // Drive one cycle of inputs at the falling edge; report whether a transfer
   // will happen at the coming rising edge and log any accept to the model
   task automatic drive(input logic v, input logic [7:0] d, input logic r, output logic xfer);
      @(negedge clk);
      in_valid  = v;
      data      = d;
      out_ready = r;
      #1;
      xfer = o_valid && r;
      if (v && o_in_ready) model_push(d);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; data = 8'h00; out_ready = 1'b0; sel = 2'd0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         vectors++;
         if ({o_in_ready, o_valid, o_code, o_none, o_multi} !== 7'b1_0_000_0_0) begin
            miscompares++;
            $display("FAIL reset[%0d]: got in_ready=%0b valid=%0b code=%0d none=%0b multi=%0b, want 1 0 0 0 0",
                     s, o_in_ready, o_valid, o_code, o_none, o_multi);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      sel = 2'd0;
      #1;
      vectors++;
      if (o_in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %0b, want 1", o_in_ready);
      end
      exp_q.delete();
      model_ptr = '{0, 0, 0};
   endtask

   task automatic test_walk();
      logic xf;
      res_t e;
      int   n_out = 0;
      sel = 2'd0;
      for (int i = 0; i <= 8; i++) begin
         drive(i < 8, (i < 8) ? 8'(1 << i) : 8'h00, 1'b1, xf);
         if (xf) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL walk_sb: got code=%0d, want no output", o_code);
            end else begin
               e = exp_q.pop_front();
               if ({o_code, o_none, o_multi} !== e) begin
                  miscompares++;
                  $display("FAIL walk_sb: got code=%0d none=%0b multi=%0b, want code=%0d none=%0b multi=%0b",
                           o_code, o_none, o_multi, e.code, e.none, e.multi);
               end
            end
            vectors++;
            if ({o_code, o_none, o_multi} !== {3'(n_out), 2'b00}) begin
               miscompares++;
               $display("FAIL walk[%0d]: got code=%0d none=%0b multi=%0b, want code=%0d none=0 multi=0",
                        n_out, o_code, o_none, o_multi, n_out);
            end
            n_out++;
         end
      end
      vectors++;
      if (n_out != 8) begin
         miscompares++;
         $display("FAIL walk_count: got %0d outputs, want 8", n_out);
      end
   endtask

   task automatic test_fixed_vs_rr();
      logic xf;
      res_t e;
      int   n_out;
      int   want_rr[5] = '{0, 2, 7, 0, 2};
      int   want;
      for (int m = 0; m < 2; m++) begin
         sel   = 2'(m);
         n_out = 0;
         for (int i = 0; i <= 5; i++) begin
            drive(i < 5, 8'b1000_0101, 1'b1, xf);
            if (xf) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL fvr_sb: got code=%0d, want no output", o_code);
               end else begin
                  e = exp_q.pop_front();
                  if ({o_code, o_none, o_multi} !== e) begin
                     miscompares++;
                     $display("FAIL fvr_sb mode=%0d: got code=%0d none=%0b multi=%0b, want code=%0d none=%0b multi=%0b",
                              m, o_code, o_none, o_multi, e.code, e.none, e.multi);
                  end
               end
               want = (m == 1) ? want_rr[n_out] : 0;
               vectors++;
               if ({o_code, o_none, o_multi} !== {3'(want), 2'b01}) begin
                  miscompares++;
                  $display("FAIL fvr[%0d] mode=%0d: got code=%0d none=%0b multi=%0b, want code=%0d none=0 multi=1",
                           n_out, m, o_code, o_none, o_multi, want);
               end
               n_out++;
            end
         end
      end
   endtask

   task automatic test_zero_multi();
      logic       xf;
      res_t       e;
      int         n_out = 0;
      logic [7:0] din [4] = '{8'b00000, 8'b10010, 8'b00000, 8'b10010};
      logic [4:0] want[4] = '{{3'd0, 2'b10}, {3'd1, 2'b01}, {3'd0, 2'b10}, {3'd4, 2'b01}};
      sel = 2'd2;
      for (int i = 0; i <= 4; i++) begin
         drive(i < 4, (i < 4) ? din[i] : 8'h00, 1'b1, xf);
         if (xf) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL zm_sb: got code=%0d, want no output", o_code);
            end else begin
               e = exp_q.pop_front();
               if ({o_code, o_none, o_multi} !== e) begin
                  miscompares++;
                  $display("FAIL zm_sb: got code=%0d none=%0b multi=%0b, want code=%0d none=%0b multi=%0b",
                           o_code, o_none, o_multi, e.code, e.none, e.multi);
               end
            end
            vectors++;
            if ({o_code, o_none, o_multi} !== want[n_out]) begin
               miscompares++;
               $display("FAIL zm[%0d]: got {code,none,multi}=%b, want %b",
                        n_out, {o_code, o_none, o_multi}, want[n_out]);
            end
            n_out++;
         end
      end
   endtask

   task automatic test_wrap();
      logic       xf;
      res_t       e;
      int         n_out = 0;
      logic [7:0] din [5] = '{8'b10000, 8'b10001, 8'b00110, 8'b00101, 8'b10001};
      logic [4:0] want[5] = '{{3'd4, 2'b00}, {3'd0, 2'b01}, {3'd1, 2'b01},
                              {3'd2, 2'b01}, {3'd4, 2'b01}};
      sel = 2'd2;
      for (int i = 0; i <= 5; i++) begin
         drive(i < 5, (i < 5) ? din[i] : 8'h00, 1'b1, xf);
         if (xf) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL wrap_sb: got code=%0d, want no output", o_code);
            end else begin
               e = exp_q.pop_front();
               if ({o_code, o_none, o_multi} !== e) begin
                  miscompares++;
                  $display("FAIL wrap_sb: got code=%0d none=%0b multi=%0b, want code=%0d none=%0b multi=%0b",
                           o_code, o_none, o_multi, e.code, e.none, e.multi);
               end
            end
            vectors++;
            if ({o_code, o_none, o_multi} !== want[n_out]) begin
               miscompares++;
               $display("FAIL wrap[%0d]: got {code,none,multi}=%b, want %b",
                        n_out, {o_code, o_none, o_multi}, want[n_out]);
            end
            n_out++;
         end
      end
   endtask

   task automatic test_backpressure();
      logic xf;
      res_t e;
      sel = 2'd0;
      drive(1'b1, 8'b0000_0100, 1'b0, xf);
      for (int h = 0; h < 3; h++) begin
         drive(1'b1, 8'b0000_0001, 1'b0, xf);
         vectors++;
         if ({o_valid, o_code, o_in_ready} !== {1'b1, 3'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got valid=%0b code=%0d in_ready=%0b, want 1 2 0",
                     h, o_valid, o_code, o_in_ready);
         end
      end
      // Release together with a new request: transfer and accept on one edge
      drive(1'b1, 8'b0000_1000, 1'b1, xf);
      vectors++;
      if (!xf || exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL bp_release: got xfer=%0b queued=%0d, want xfer=1 queued>0", xf, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({o_code, o_none, o_multi} !== e) begin
            miscompares++;
            $display("FAIL bp_release_sb: got code=%0d none=%0b multi=%0b, want code=%0d none=%0b multi=%0b",
                     o_code, o_none, o_multi, e.code, e.none, e.multi);
         end
      end
      drive(1'b0, 8'h00, 1'b0, xf);
      vectors++;
      if ({o_valid, o_code} !== {1'b1, 3'd3}) begin
         miscompares++;
         $display("FAIL bp_next: got valid=%0b code=%0d, want valid=1 code=3", o_valid, o_code);
      end
      drive(1'b0, 8'h00, 1'b1, xf);
      vectors++;
      if (!xf || exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL bp_drain: got xfer=%0b queued=%0d, want xfer=1 queued>0", xf, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({o_code, o_none, o_multi} !== e) begin
            miscompares++;
            $display("FAIL bp_drain_sb: got code=%0d none=%0b multi=%0b, want code=%0d none=%0b multi=%0b",
                     o_code, o_none, o_multi, e.code, e.none, e.multi);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic xf;
      res_t e;
      sel = 2'd1;
      // ptr is 3 here; bit 4 wins and moves ptr to 5
      drive(1'b1, 8'b0001_0000, 1'b1, xf);
      drive(1'b0, 8'h00, 1'b1, xf);
      vectors++;
      if (!xf || exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL rm_setup: got xfer=%0b queued=%0d, want xfer=1 queued>0", xf, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({o_code, o_none, o_multi} !== e || o_code !== 3'd4) begin
            miscompares++;
            $display("FAIL rm_setup_sb: got code=%0d none=%0b multi=%0b, want code=%0d none=%0b multi=%0b",
                     o_code, o_none, o_multi, e.code, e.none, e.multi);
         end
      end
      // Zero vector leaves an untaken result without moving ptr off 5
      drive(1'b1, 8'h00, 1'b0, xf);
      drive(1'b0, 8'h00, 1'b0, xf);
      vectors++;
      if ({o_valid, o_none} !== 2'b11) begin
         miscompares++;
         $display("FAIL rm_held: got valid=%0b none=%0b, want 1 1", o_valid, o_none);
      end
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; data = 8'hFF; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; data = 8'h00; out_ready = 1'b0;
      #1;
      exp_q.delete();
      model_ptr = '{0, 0, 0};
      vectors++;
      if ({o_valid, o_code, o_none, o_multi, o_in_ready} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL rm_after_rst: got valid=%0b code=%0d none=%0b multi=%0b in_ready=%0b, want 0 0 0 0 1",
                  o_valid, o_code, o_none, o_multi, o_in_ready);
      end
      drive(1'b1, 8'hFF, 1'b1, xf);
      drive(1'b0, 8'h00, 1'b1, xf);
      vectors++;
      if (!xf || exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL rm_post: got xfer=%0b queued=%0d, want xfer=1 queued>0", xf, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({o_code, o_none, o_multi} !== e || o_code !== 3'd0) begin
            miscompares++;
            $display("FAIL rm_post_sb: got code=%0d none=%0b multi=%0b, want code=0 none=%0b multi=%0b",
                     o_code, o_none, o_multi, e.none, e.multi);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by time limit, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_walk();
      test_fixed_vs_rr();
      test_zero_multi();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover: got %0d queued results, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
